// File: rtl/argmax_classifier_if.sv
// Score/result bundle between the output FC layer (master) and argmax_classifier (slave).
// ARGMAX_MARGIN_EN adds the unsigned best-minus-runner-up margin signal.
interface argmax_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16
);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic signed [DATA_W-1:0] scores [NUM_CLASSES];
  logic                     valid_in;
  logic                     in_ready;
  logic [IDX_W-1:0]         class_idx;
  logic signed [DATA_W-1:0] max_score;
  logic                     valid_out;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_W-1:0]        margin;

  modport master (
    output scores, valid_in,
    input  in_ready, class_idx, max_score, valid_out, margin
  );

  modport slave (
    input  scores, valid_in,
    output in_ready, class_idx, max_score, valid_out, margin
  );
`else
  modport master (
    output scores, valid_in,
    input  in_ready, class_idx, max_score, valid_out
  );

  modport slave (
    input  scores, valid_in,
    output in_ready, class_idx, max_score, valid_out
  );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Serial argmax over one captured frame of signed class scores, one compare per clock.
// Optional ARGMAX_MARGIN_EN: also tracks the runner-up and reports a saturated margin.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  argmax_classifier_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q;
  logic                     accept;

  logic signed [DATA_W-1:0] bank_p0 [NUM_CLASSES];
  logic signed [DATA_W-1:0] cur_p0;
  logic signed [DATA_W-1:0] best_p1;
  logic [IDX_W-1:0]         best_idx_p1;
  logic                     gt_best_p0;

  logic                     vld_p2;
  logic [IDX_W-1:0]         class_idx_p2;
  logic signed [DATA_W-1:0] max_score_p2;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W:0] MARGIN_MAX = {2'b00, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] second_p1;
  logic                     gt_second_p0;
  logic [DATA_W-1:0]        margin_p2;

  // Difference is taken one bit wider so full-scale spreads cannot wrap.
  function automatic logic [DATA_W-1:0] sat_margin(
    input logic signed [DATA_W-1:0] hi,
    input logic signed [DATA_W-1:0] lo
  );
    logic signed [DATA_W:0] diff;
    diff = {hi[DATA_W-1], hi} - {lo[DATA_W-1], lo};
    if (diff > MARGIN_MAX)
      return MARGIN_MAX[DATA_W-1:0];
    else if (diff < 0)
      return '0;
    else
      return diff[DATA_W-1:0];
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    bus.in_ready = (state_q != SCAN);
    accept      = bus.valid_in && (state_q != SCAN);
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (cnt_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_p0     = bank_p0[cnt_q];
    gt_best_p0 = (cur_p0 > best_p1);
`ifdef ARGMAX_MARGIN_EN
    gt_second_p0 = (cur_p0 > second_p1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vld_p2       <= 1'b0;
      class_idx_p2 <= '0;
      max_score_p2 <= '0;
`ifdef ARGMAX_MARGIN_EN
      margin_p2    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vld_p2  <= (state_q == DONE);
      if (accept)
        cnt_q <= IDX_W'(1);
      else if (state_q == SCAN)
        cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
      if (state_q == DONE) begin
        class_idx_p2 <= best_idx_p1;
        max_score_p2 <= best_p1;
`ifdef ARGMAX_MARGIN_EN
        margin_p2    <= sat_margin(best_p1, second_p1);
`endif
      end
    end
  end

  // p0: frame capture; p1: running best updated from the captured bank only
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_p0     <= bus.scores;
      best_p1     <= bus.scores[0];
      best_idx_p1 <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_p1   <= SCORE_MIN;
`endif
    end else if (state_q == SCAN) begin
      if (gt_best_p0) begin
        best_p1     <= cur_p0;
        best_idx_p1 <= cnt_q;
`ifdef ARGMAX_MARGIN_EN
        second_p1   <= best_p1;
`endif
      end
`ifdef ARGMAX_MARGIN_EN
      else if (gt_second_p0) begin
        second_p1 <= cur_p0;
      end
`endif
    end
  end

  // p2: registered results, held between pulses
  assign bus.valid_out = vld_p2;
  assign bus.class_idx = class_idx_p2;
  assign bus.max_score = max_score_p2;
`ifdef ARGMAX_MARGIN_EN
  assign bus.margin    = margin_p2;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: latency, ties, extremes, ignored input, back-to-back and abort.
module tb_argmax_classifier;
  localparam int NC = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  argmax_classifier_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bus ();

  argmax_classifier #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NC; i++) bus.scores[i] = 16'(v);
  endtask

  task automatic send();
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic await_result(input string tag, input int lat, input int idx, input int score, input int mrg);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.valid_out && n < 40);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_idx"}, 32'(bus.class_idx), idx);
    chk({tag, "_score"}, 32'(bus.max_score), score);
`ifdef ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, 32'(bus.margin), mrg);
`else
    if (mrg < 0) $display("note: negative margin request ignored for %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int seen;
    bus.valid_in = 1'b0;
    set_all(0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_vout", 32'(bus.valid_out), 0);
    chk("rst_idx", 32'(bus.class_idx), 0);
    chk("rst_score", 32'(bus.max_score), 0);
`ifdef ARGMAX_MARGIN_EN
    chk("rst_margin", 32'(bus.margin), 0);
`endif

    // ascending ramp
    for (int i = 0; i < NC; i++) bus.scores[i] = 16'(i * 100);
    send();
    chk("t1_busy", 32'(bus.in_ready), 0);
    await_result("t1", 10, 9, 900, 100);
    step();
    chk("t1_pulse", 32'(bus.valid_out), 0);
    chk("t1_hold", 32'(bus.class_idx), 9);

    // all negative
    set_all(-500);
    bus.scores[3] = -16'sd1;
    send();
    await_result("t2", 10, 3, -1, 499);

    // tie resolves to lowest index
    step();
    set_all(0);
    bus.scores[2] = 16'sd1234;
    bus.scores[7] = 16'sd1234;
    send();
    await_result("t3", 10, 2, 1234, 0);

    // full-scale extremes
    step();
    set_all(-32768);
    bus.scores[0] = 16'sd32767;
    send();
    await_result("t4", 10, 0, 32767, 32767);

    // ignored valid_in during scan, score changes after capture, back-to-back frame
    step();
    set_all(10);
    bus.scores[5] = 16'sd777;
    send();
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) chk("t5_busy", 32'(bus.in_ready), 0);
      if (k >= 3 && k <= 8) begin
        bus.valid_in = 1'b1;
        set_all(5000);
      end else begin
        bus.valid_in = 1'b0;
      end
      if (k == 9) begin
        chk("t5_done_ready", 32'(bus.in_ready), 1);
        chk("t5_done_vout", 32'(bus.valid_out), 0);
        set_all(-7);
        bus.scores[8] = 16'sd42;
        bus.valid_in = 1'b1;
      end
    end
    step();
    bus.valid_in = 1'b0;
    chk("t5a_vout", 32'(bus.valid_out), 1);
    chk("t5a_idx", 32'(bus.class_idx), 5);
    chk("t5a_score", 32'(bus.max_score), 777);
`ifdef ARGMAX_MARGIN_EN
    chk("t5a_margin", 32'(bus.margin), 767);
`endif
    chk("t5b_busy", 32'(bus.in_ready), 0);
    await_result("t5b", 10, 8, 42, 49);
    step();
    chk("t5b_pulse", 32'(bus.valid_out), 0);

    // reset in the middle of a scan
    set_all(1);
    bus.scores[6] = 16'sd300;
    send();
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_vout", 32'(bus.valid_out), 0);
    chk("t6_idx", 32'(bus.class_idx), 0);
    chk("t6_score", 32'(bus.max_score), 0);
    chk("t6_ready", 32'(bus.in_ready), 1);
`ifdef ARGMAX_MARGIN_EN
    chk("t6_margin", 32'(bus.margin), 0);
`endif
    seen = 0;
    repeat (15) begin
      step();
      if (bus.valid_out) seen++;
    end
    chk("t6_nopulse", seen, 0);
    send();
    await_result("t6_new", 10, 6, 300, 299);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
